synaptic_weight_accumulator: RTL and testbench

- Producer of the ExWeightSum/InWeightSum inputs consumed by ConductanceLIFNeuronUnit, one postsynaptic neuron per request.
- Per request: latches a presynaptic spike vector and a postsynaptic index, then scans the presynaptic neurons one per cycle.
- For each spiking presynaptic neuron, reads its synaptic weight from an external synchronous weight RAM and adds it to the excitatory or inhibitory sum, as set by the presynaptic neuron's type.
- Returns both Q32.32 sums with a one-cycle valid pulse at a fixed latency.

---
 rtl/synaptic_weight_accumulator.sv | 173 +++++++++++++++++
 tb/tb_synaptic_weight_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_weight_accumulator.sv
// Synaptic weight accumulator for one postsynaptic neuron per request.
// Scans NUM_PRE presynaptic neurons one per cycle and reads the weight of
// each spiking one from an external synchronous RAM. Each weight is added,
// with saturation, to the excitatory or inhibitory sum. SumValid pulses for
// one cycle at a fixed latency of NUM_PRE+2 cycles after Start is accepted.
module synaptic_weight_accumulator #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NUM_PRE         = 16,
  parameter int PRE_ADDR_WIDTH  = 4,
  parameter int POST_ADDR_WIDTH = 4,
  parameter int NUM_EX          = 12
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  Start,
  input  logic [POST_ADDR_WIDTH-1:0]            PostIndex,
  input  logic [NUM_PRE-1:0]                    SpikeVector,
  output logic                                  Busy,
  output logic                                  WtRdEn,
  output logic [PRE_ADDR_WIDTH+POST_ADDR_WIDTH-1:0] WtRdAddr,
  input  logic [DATA_WIDTH-1:0]                 WtRdData,
  output logic [DATA_WIDTH-1:0]                 ExWeightSum,
  output logic [DATA_WIDTH-1:0]                 InWeightSum,
  output logic                                  SumValid,
  output logic                                  Saturated
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [NUM_PRE-1:0]          spike_r;
  logic [POST_ADDR_WIDTH-1:0]  post_r;
  logic [PRE_ADDR_WIDTH-1:0]   pre_cnt_r;
  logic                        rd_vld_r;
  logic                        rd_ex_r;
  logic [DATA_WIDTH-1:0]       ex_sum_r;
  logic [DATA_WIDTH-1:0]       in_sum_r;
  logic                        sat_r;
  logic                        sum_valid_r;
  logic                        busy_r;
  logic                        accept_s;
  logic [DATA_WIDTH:0]         acc_s;

  // Signed add of two DATA_WIDTH values in DATA_WIDTH+1 bits, clipped back to
  // DATA_WIDTH. Result MSB is the clip flag, lower bits the clipped sum.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] wide;
    wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      sat_add = {1'b1, wide[DATA_WIDTH], {(DATA_WIDTH-1){~wide[DATA_WIDTH]}}};
    end else begin
      sat_add = {1'b0, wide[DATA_WIDTH-1:0]};
    end
  endfunction

  assign accept_s = (state_r == ST_IDLE) && Start;

  // Next-state decode of the request sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) state_s = ST_SCAN;
        else       state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (pre_cnt_r == PRE_ADDR_WIDTH'(NUM_PRE - 1)) state_s = ST_DRAIN;
        else                                           state_s = ST_SCAN;
      end
      ST_DRAIN: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Weight RAM read request, decoded from registered scan state only.
  always_comb begin
    WtRdAddr = {pre_cnt_r, post_r};
    if (state_r == ST_SCAN) begin
      WtRdEn = spike_r[pre_cnt_r];
    end else begin
      WtRdEn = 1'b0;
    end
  end

  // Saturating add of the returning weight into the sum selected by its type.
  always_comb begin
    if (rd_ex_r) begin
      acc_s = sat_add(ex_sum_r, WtRdData);
    end else begin
      acc_s = sat_add(in_sum_r, WtRdData);
    end
  end

  // Sequencer state, request latches and scan counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      spike_r   <= '0;
      post_r    <= '0;
      pre_cnt_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        spike_r   <= SpikeVector;
        post_r    <= PostIndex;
        pre_cnt_r <= '0;
      end else if (state_r == ST_SCAN) begin
        pre_cnt_r <= pre_cnt_r + PRE_ADDR_WIDTH'(1);
      end
    end
  end

  // One-stage tag pipeline matching the RAM read latency: valid and EX/IN type.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_vld_r <= 1'b0;
      rd_ex_r  <= 1'b0;
    end else begin
      rd_vld_r <= WtRdEn;
      rd_ex_r  <= ({1'b0, pre_cnt_r} < (PRE_ADDR_WIDTH + 1)'(NUM_EX));
    end
  end

  // Sum registers and sticky saturation flag; cleared when a request is accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ex_sum_r <= '0;
      in_sum_r <= '0;
      sat_r    <= 1'b0;
    end else if (accept_s) begin
      ex_sum_r <= '0;
      in_sum_r <= '0;
      sat_r    <= 1'b0;
    end else if (rd_vld_r) begin
      if (rd_ex_r) begin
        ex_sum_r <= acc_s[DATA_WIDTH-1:0];
      end else begin
        in_sum_r <= acc_s[DATA_WIDTH-1:0];
      end
      sat_r <= sat_r | acc_s[DATA_WIDTH];
    end else begin
      sat_r <= sat_r;
    end
  end

  // Completion pulse, one cycle after the sequencer sits in DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sum_valid_r <= 1'b0;
    end else begin
      sum_valid_r <= (state_r == ST_DONE);
    end
  end

  assign Busy        = busy_r;
  assign ExWeightSum = ex_sum_r;
  assign InWeightSum = in_sum_r;
  assign SumValid    = sum_valid_r;
  assign Saturated   = sat_r;

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Self-checking bench for synaptic_weight_accumulator: directed vector table,
// randomized requests against a reference model, and multi-cycle corner cases.
module tb_synaptic_weight_accumulator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  PostIndex = 4'd0;
  logic [15:0] SpikeVector = 16'd0;
  logic        Busy;
  logic        WtRdEn;
  logic [7:0]  WtRdAddr;
  logic [63:0] WtRdData;
  logic [63:0] ExWeightSum;
  logic [63:0] InWeightSum;
  logic        SumValid;
  logic        Saturated;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:255];

  synaptic_weight_accumulator dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PostIndex(PostIndex),
    .SpikeVector(SpikeVector), .Busy(Busy), .WtRdEn(WtRdEn), .WtRdAddr(WtRdAddr),
    .WtRdData(WtRdData), .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
    .SumValid(SumValid), .Saturated(Saturated)
  );

  always #5 Clock = ~Clock;

  // Synchronous weight RAM: data one cycle after the read enable.
  always @(posedge Clock) begin
    if (WtRdEn) WtRdData <= mem[WtRdAddr];
  end

  typedef struct {
    logic [15:0] spike;
    logic [3:0]  post;
    logic [63:0] w_all;
    logic [63:0] exp_ex;
    logic [63:0] exp_in;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [63:0] w);
    for (int a = 0; a < 256; a++) mem[a] = w;
  endtask

  // Reference: in index order, add each spiking weight into the EX (index<12)
  // or IN sum using wide arithmetic and clamp to the signed 64-bit range.
  task automatic model(input logic [15:0] sp, input logic [3:0] po,
                       output logic [63:0] ex, output logic [63:0] in, output logic sat);
    logic signed [64:0] hi, lo, t;
    logic signed [63:0] acc_ex, acc_in, w;
    hi = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    lo = -65'sh0_8000_0000_0000_0000;
    acc_ex = 64'sd0;
    acc_in = 64'sd0;
    sat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sp[i]) begin
        w = mem[{i[3:0], po}];
        t = (i < 12) ? acc_ex : acc_in;
        t = t + w;
        if (t > hi) begin t = hi; sat = 1'b1; end
        else if (t < lo) begin t = lo; sat = 1'b1; end
        else begin t = t; end
        if (i < 12) acc_ex = t[63:0];
        else        acc_in = t[63:0];
      end
    end
    ex = acc_ex;
    in = acc_in;
  endtask

  // Issue one request (caller is at a negedge) and check the whole transaction.
  task automatic run_req(input logic [15:0] sp, input logic [3:0] po,
                         input logic [63:0] e_ex, input logic [63:0] e_in,
                         input logic e_sat, input bit disturb);
    int lat = -1;
    int busy_n = 0;
    int bad_addr = 0;
    int late_rd = 0;
    int extra_valid = 0;
    logic [15:0] pat = 16'd0;
    Start = 1'b1; SpikeVector = sp; PostIndex = po;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clock); #1;
      if (n == 0) begin
        Start = 1'b0;
        if (disturb) begin SpikeVector = ~sp; PostIndex = po + 4'd1; end
      end
      if (disturb && n == 5) Start = 1'b1;
      if (disturb && n == 6) Start = 1'b0;
      if (Busy) busy_n++;
      if (n < 16) begin
        pat[n] = WtRdEn;
        if (WtRdEn && WtRdAddr !== {n[3:0], po}) bad_addr++;
      end else if (WtRdEn) begin
        late_rd++;
      end
      if (SumValid) begin lat = n; break; end
    end
    chk("latency", 64'(lat), 64'd18);
    chk("busy_cycles", 64'(busy_n), 64'd18);
    chk("read_pattern", 64'(pat), 64'(sp));
    chk("read_addr", 64'(bad_addr), 64'd0);
    chk("late_reads", 64'(late_rd), 64'd0);
    chk("ex_sum", ExWeightSum, e_ex);
    chk("in_sum", InWeightSum, e_in);
    chk("saturated", 64'(Saturated), 64'(e_sat));
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock); #1;
      if (SumValid) extra_valid++;
    end
    chk("single_valid", 64'(extra_valid), 64'd0);
    chk("ex_hold", ExWeightSum, e_ex);
    chk("busy_idle", 64'(Busy), 64'd0);
  endtask

  initial begin
    logic [63:0] m_ex, m_in, r;
    logic        m_sat;
    logic [15:0] sp;
    logic [3:0]  po;
    int          nvalid;

    vecs[0] = '{16'h0001, 4'd3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 1'b0};
    vecs[1] = '{16'hFFFF, 4'd5, 64'h0000_0000_8000_0000, 64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, 1'b0};
    vecs[2] = '{16'h0000, 4'd9, 64'h0000_0000_1234_5678, 64'd0, 64'd0, 1'b0};
    vecs[3] = '{16'h0003, 4'd2, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    vecs[4] = '{16'h0003, 4'd2, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'd0, 1'b0};
    vecs[5] = '{16'hF000, 4'd0, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'hFFFF_FFFC_0000_0000, 1'b0};
    vecs[6] = '{16'h0003, 4'd15, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[7] = '{16'hC000, 4'd7, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 1'b1};

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_outputs", {59'd0, Busy, WtRdEn, SumValid, Saturated, 1'b0}, 64'd0);
    chk("reset_sums", ExWeightSum | InWeightSum, 64'd0);

    // Directed table; first Start on the first edge after reset release
    @(negedge Clock);
    Reset = 1'b0;
    for (int v = 0; v < 8; v++) begin
      fill_mem(vecs[v].w_all);
      if (v > 0) @(negedge Clock);
      run_req(vecs[v].spike, vecs[v].post, vecs[v].exp_ex, vecs[v].exp_in,
              vecs[v].exp_sat, 1'b0);
    end

    // Start re-pulsed and inputs changed while busy
    fill_mem(64'h0000_0000_4000_0000);
    @(negedge Clock);
    run_req(16'h8421, 4'd6, 64'h0000_0000_C000_0000, 64'h0000_0000_4000_0000, 1'b0, 1'b1);

    // Reset asserted mid-scan at PreCnt=7
    fill_mem(64'h0000_0001_0000_0000);
    @(negedge Clock);
    Start = 1'b1; SpikeVector = 16'hFFFF; PostIndex = 4'd4;
    for (int n = 0; n < 8; n++) begin
      @(posedge Clock); #1;
      if (n == 0) Start = 1'b0;
    end
    chk("pre_reset_sum", 64'(ExWeightSum != 64'd0), 64'd1);
    Reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {60'd0, Busy, WtRdEn, SumValid, Saturated}, 64'd0);
    chk("async_reset_sums", ExWeightSum | InWeightSum, 64'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge Clock); #1;
      if (SumValid || Busy) nvalid++;
    end
    chk("aborted_no_valid", 64'(nvalid), 64'd0);
    @(negedge Clock);
    run_req(16'hFFFF, 4'd4, 64'h0000_000C_0000_0000, 64'h0000_0004_0000_0000, 1'b0, 1'b0);

    // Randomized requests against the reference model
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < 256; a++) begin
        r = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) mem[a] = r;
        else mem[a] = {{32{r[31]}}, r[31:0]};
      end
      sp = 16'($urandom);
      po = 4'($urandom);
      model(sp, po, m_ex, m_in, m_sat);
      @(negedge Clock);
      run_req(sp, po, m_ex, m_in, m_sat, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
